// File: rtl/systolic_pkg.sv
// Shared word type, array size and MAC rule for the 4x4 systolic array.
// Build with SYSTOLIC_SAT_EN to make the accumulate saturate instead of wrapping.
package systolic_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned N      = 4;

  typedef logic signed [DATA_W-1:0] data_t;

`ifdef SYSTOLIC_SAT_EN
  localparam data_t SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam data_t SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
`endif

  // Product keeps only its low DATA_W bits; the accumulate wraps or saturates.
  function automatic data_t mac(input data_t ps_in, input data_t a_in, input data_t b_in);
    data_t prod;
    data_t sum;
    prod = a_in * b_in;
    sum  = ps_in + prod;
`ifdef SYSTOLIC_SAT_EN
    if ((ps_in[DATA_W-1] == prod[DATA_W-1]) && (sum[DATA_W-1] != ps_in[DATA_W-1]))
      sum = ps_in[DATA_W-1] ? SAT_MIN : SAT_MAX;
`endif
    return sum;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One weight-stationary processing element: activation, weight and partial-sum registers.
module systolic_pe
  import systolic_pkg::*;
(
  input  logic  Clock,
  input  logic  rst_n,
  input  logic  data_clear,
  input  logic  en_shift_right,
  input  logic  en_shift_bottom,
  input  data_t a_in,
  input  data_t b_in,
  input  data_t ps_in,
  output data_t a_out,
  output data_t b_out,
  output data_t ps_out
);

  data_t a_reg;
  data_t b_reg;
  data_t ps_reg;

  // The MAC reads the pre-edge b_reg, so a simultaneous weight shift takes effect next step.
  always_ff @(posedge Clock or negedge rst_n) begin
    if (!rst_n) begin
      a_reg  <= '0;
      b_reg  <= '0;
      ps_reg <= '0;
    end else if (data_clear) begin
      a_reg  <= '0;
      b_reg  <= '0;
      ps_reg <= '0;
    end else begin
      if (en_shift_bottom) begin
        b_reg <= b_in;
      end
      if (en_shift_right) begin
        a_reg  <= a_in;
        ps_reg <= mac(ps_in, a_in, b_reg);
      end
    end
  end

  assign a_out  = a_reg;
  assign b_out  = b_reg;
  assign ps_out = ps_reg;

endmodule

// File: rtl/systolic_array_4x4.sv
// 4x4 weight-stationary systolic MAC array; results leave the bottom row.
// Optional macro: SYSTOLIC_SAT_EN (saturating accumulate).
module systolic_array_4x4
  import systolic_pkg::*;
(
  input  logic  Clock,
  input  logic  rst_n,
  input  logic  data_clear,
  input  logic  en_shift_right,
  input  logic  en_shift_bottom,
  input  data_t a_left_in_flat     [N],
  input  data_t b_top_in_flat      [N],
  input  data_t ps_top_in_flat     [N],
  output data_t ps_bottom_out_flat [N]
);

  data_t a_out_w  [N][N];
  data_t b_out_w  [N][N];
  data_t ps_out_w [N][N];

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      data_t a_in_w;
      data_t b_in_w;
      data_t ps_in_w;

      if (c == 0) begin : g_a_edge
        assign a_in_w = a_left_in_flat[r];
      end else begin : g_a_inner
        assign a_in_w = a_out_w[r][c-1];
      end

      if (r == 0) begin : g_top_edge
        assign b_in_w  = b_top_in_flat[c];
        assign ps_in_w = ps_top_in_flat[c];
      end else begin : g_top_inner
        assign b_in_w  = b_out_w[r-1][c];
        assign ps_in_w = ps_out_w[r-1][c];
      end

      systolic_pe u_pe (
        .Clock           (Clock),
        .rst_n           (rst_n),
        .data_clear      (data_clear),
        .en_shift_right  (en_shift_right),
        .en_shift_bottom (en_shift_bottom),
        .a_in            (a_in_w),
        .b_in            (b_in_w),
        .ps_in           (ps_in_w),
        .a_out           (a_out_w[r][c]),
        .b_out           (b_out_w[r][c]),
        .ps_out          (ps_out_w[r][c])
      );
    end

    // Activations off the right edge and weights off the bottom edge go nowhere.
    logic unused_edge_r;
    assign unused_edge_r = ^{a_out_w[r][N-1], b_out_w[N-1][r]};

    assign ps_bottom_out_flat[r] = ps_out_w[N-1][r];
  end

endmodule

// File: tb/tb_systolic_array_4x4.sv
// Directed self-checking bench for systolic_array_4x4 (wrap and SYSTOLIC_SAT_EN builds).
module tb_systolic_array_4x4;
  import systolic_pkg::*;

  logic  Clock;
  logic  rst_n;
  logic  data_clear;
  logic  en_shift_right;
  logic  en_shift_bottom;
  data_t a_left_in_flat     [4];
  data_t b_top_in_flat      [4];
  data_t ps_top_in_flat     [4];
  data_t ps_bottom_out_flat [4];

  int pass_cnt = 0;
  int chk_cnt  = 0;
  data_t exp_v [4];

  systolic_array_4x4 dut (
    .Clock              (Clock),
    .rst_n              (rst_n),
    .data_clear         (data_clear),
    .en_shift_right     (en_shift_right),
    .en_shift_bottom    (en_shift_bottom),
    .a_left_in_flat     (a_left_in_flat),
    .b_top_in_flat      (b_top_in_flat),
    .ps_top_in_flat     (ps_top_in_flat),
    .ps_bottom_out_flat (ps_bottom_out_flat)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // One clock with the given controls; inputs are sampled 1 ns after the edge.
  task automatic cyc(input logic clr, input logic sr, input logic sb);
    @(negedge Clock);
    data_clear      = clr;
    en_shift_right  = sr;
    en_shift_bottom = sb;
    @(posedge Clock);
    #1;
    data_clear      = 1'b0;
    en_shift_right  = 1'b0;
    en_shift_bottom = 1'b0;
  endtask

  task automatic shifts(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0);
  endtask

  task automatic load_b_all(input data_t v);
    cyc(1'b1, 1'b0, 1'b0);
    b_top_in_flat = '{v, v, v, v};
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    data_clear = 1'b0; en_shift_right = 1'b0; en_shift_bottom = 1'b0;
    a_left_in_flat = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
    b_top_in_flat  = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
    ps_top_in_flat = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    rst_n = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) begin
      chk_cnt++;
      if (ps_bottom_out_flat[c] !== 16'sd0)
        $display("FAIL reset_init col%0d got %h expected 0000", c, ps_bottom_out_flat[c]);
      else pass_cnt++;
    end
    load_b_all(16'sd1);
    a_left_in_flat = '{16'sd1, 16'sd1, 16'sd1, 16'sd1};
    shifts(8);
    for (int c = 0; c < 4; c++) begin
      chk_cnt++;
      if (ps_bottom_out_flat[c] !== 16'sd4)
        $display("FAIL reset_preload col%0d got %h expected 0004", c, ps_bottom_out_flat[c]);
      else pass_cnt++;
    end
    @(negedge Clock);
    #2;
    rst_n = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      chk_cnt++;
      if (ps_bottom_out_flat[c] !== 16'sd0)
        $display("FAIL reset_async col%0d got %h expected 0000", c, ps_bottom_out_flat[c]);
      else pass_cnt++;
    end
    @(negedge Clock);
    rst_n = 1'b1;
    a_left_in_flat = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
  endtask

  task automatic test_weight_load();
    cyc(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) b_top_in_flat[c] = data_t'(4 * k + c + 1);
      cyc(1'b0, 1'b0, 1'b1);
      for (int c = 0; c < 4; c++) begin
        chk_cnt++;
        if (ps_bottom_out_flat[c] !== 16'sd0)
          $display("FAIL weight_load_quiet k%0d col%0d got %h expected 0000", k, c, ps_bottom_out_flat[c]);
        else pass_cnt++;
      end
    end
    // Row 3 only: exposes the first-loaded weights.
    a_left_in_flat = '{16'sd0, 16'sd0, 16'sd0, 16'sd1};
    shifts(8);
    exp_v = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
    for (int c = 0; c < 4; c++) begin
      chk_cnt++;
      if (ps_bottom_out_flat[c] !== exp_v[c])
        $display("FAIL weight_row3 col%0d got %h expected %h", c, ps_bottom_out_flat[c], exp_v[c]);
      else pass_cnt++;
    end
    // Row 0 only: exposes the last-loaded weights.
    a_left_in_flat = '{16'sd1, 16'sd0, 16'sd0, 16'sd0};
    shifts(10);
    exp_v = '{16'sd13, 16'sd14, 16'sd15, 16'sd16};
    for (int c = 0; c < 4; c++) begin
      chk_cnt++;
      if (ps_bottom_out_flat[c] !== exp_v[c])
        $display("FAIL weight_row0 col%0d got %h expected %h", c, ps_bottom_out_flat[c], exp_v[c]);
      else pass_cnt++;
    end
    a_left_in_flat = '{16'sd1, 16'sd1, 16'sd1, 16'sd1};
    shifts(10);
    exp_v = '{16'sd28, 16'sd32, 16'sd36, 16'sd40};
    for (int c = 0; c < 4; c++) begin
      chk_cnt++;
      if (ps_bottom_out_flat[c] !== exp_v[c])
        $display("FAIL weight_colsum col%0d got %h expected %h", c, ps_bottom_out_flat[c], exp_v[c]);
      else pass_cnt++;
    end
  endtask

  task automatic test_both_enables();
    cyc(1'b1, 1'b0, 1'b0);
    a_left_in_flat = '{16'sd1, 16'sd0, 16'sd0, 16'sd0};
    ps_top_in_flat = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
    b_top_in_flat  = '{16'sd5, 16'sd5, 16'sd5, 16'sd5};
    cyc(1'b0, 1'b1, 1'b1);
    shifts(3);
    for (int c = 0; c < 4; c++) begin
      chk_cnt++;
      if (ps_bottom_out_flat[c] !== 16'sd0)
        $display("FAIL both_en_old_b col%0d got %h expected 0000", c, ps_bottom_out_flat[c]);
      else pass_cnt++;
    end
    shifts(1);
    exp_v = '{16'sd5, 16'sd5, 16'sd0, 16'sd0};
    for (int c = 0; c < 4; c++) begin
      chk_cnt++;
      if (ps_bottom_out_flat[c] !== exp_v[c])
        $display("FAIL both_en_next col%0d got %h expected %h", c, ps_bottom_out_flat[c], exp_v[c]);
      else pass_cnt++;
    end
  endtask

  task automatic test_steady_mac();
    load_b_all(16'sd1);
    a_left_in_flat = '{16'sd1, 16'sd1, 16'sd1, 16'sd1};
    ps_top_in_flat = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
    shifts(8);
    for (int c = 0; c < 4; c++) begin
      chk_cnt++;
      if (ps_bottom_out_flat[c] !== 16'sd4)
        $display("FAIL steady_mac col%0d got %h expected 0004", c, ps_bottom_out_flat[c]);
      else pass_cnt++;
    end
    ps_top_in_flat = '{16'sd10, 16'sd10, 16'sd10, 16'sd10};
    shifts(8);
    for (int c = 0; c < 4; c++) begin
      chk_cnt++;
      if (ps_bottom_out_flat[c] !== 16'sd14)
        $display("FAIL steady_seed col%0d got %h expected 000e", c, ps_bottom_out_flat[c]);
      else pass_cnt++;
    end
  endtask

  task automatic test_clear_priority();
    b_top_in_flat = '{16'sd7, 16'sd7, 16'sd7, 16'sd7};
    cyc(1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) begin
      chk_cnt++;
      if (ps_bottom_out_flat[c] !== 16'sd0)
        $display("FAIL clear_prio col%0d got %h expected 0000", c, ps_bottom_out_flat[c]);
      else pass_cnt++;
    end
    a_left_in_flat = '{16'sd1, 16'sd1, 16'sd1, 16'sd1};
    shifts(8);
    for (int c = 0; c < 4; c++) begin
      chk_cnt++;
      if (ps_bottom_out_flat[c] !== 16'sd10)
        $display("FAIL clear_b_zero col%0d got %h expected 000a", c, ps_bottom_out_flat[c]);
      else pass_cnt++;
    end
  endtask

  task automatic test_hold();
    a_left_in_flat = '{16'sd7, 16'sd7, 16'sd7, 16'sd7};
    ps_top_in_flat = '{16'sd99, 16'sd99, 16'sd99, 16'sd99};
    b_top_in_flat  = '{16'sd3, 16'sd3, 16'sd3, 16'sd3};
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 4; c++) begin
        chk_cnt++;
        if (ps_bottom_out_flat[c] !== 16'sd10)
          $display("FAIL hold cyc%0d col%0d got %h expected 000a", k, c, ps_bottom_out_flat[c]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_overflow();
    // Row 0 only: 0x7FFF + truncated 0x8000 = 0xFFFF in both builds.
    load_b_all(16'sh4000);
    a_left_in_flat = '{16'sd2, 16'sd0, 16'sd0, 16'sd0};
    ps_top_in_flat = '{16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF};
    shifts(8);
    for (int c = 0; c < 4; c++) begin
      chk_cnt++;
      if (ps_bottom_out_flat[c] !== 16'shFFFF)
        $display("FAIL ovf_row0 col%0d got %h expected ffff", c, ps_bottom_out_flat[c]);
      else pass_cnt++;
    end
    // All rows add 0x8000: wraps back to 0x7FFF, or pins at 0x8000 when saturating.
    load_b_all(16'sh4000);
    a_left_in_flat = '{16'sd2, 16'sd2, 16'sd2, 16'sd2};
    shifts(8);
`ifdef SYSTOLIC_SAT_EN
    exp_v = '{16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000};
`else
    exp_v = '{16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF};
`endif
    for (int c = 0; c < 4; c++) begin
      chk_cnt++;
      if (ps_bottom_out_flat[c] !== exp_v[c])
        $display("FAIL ovf_all_rows col%0d got %h expected %h", c, ps_bottom_out_flat[c], exp_v[c]);
      else pass_cnt++;
    end
    // Positive overflow: 1 + 0x7FFF.
    load_b_all(16'sd1);
    a_left_in_flat = '{16'sh7FFF, 16'sd0, 16'sd0, 16'sd0};
    ps_top_in_flat = '{16'sd1, 16'sd1, 16'sd1, 16'sd1};
    shifts(8);
`ifdef SYSTOLIC_SAT_EN
    exp_v = '{16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF};
`else
    exp_v = '{16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000};
`endif
    for (int c = 0; c < 4; c++) begin
      chk_cnt++;
      if (ps_bottom_out_flat[c] !== exp_v[c])
        $display("FAIL ovf_positive col%0d got %h expected %h", c, ps_bottom_out_flat[c], exp_v[c]);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_weight_load();
    test_both_enables();
    test_steady_mac();
    test_clear_priority();
    test_hold();
    test_overflow();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
